tone_decoder: RTL
=================

Name: tone_decoder

Overview:
Receive-side counterpart of the beep tone generator. Measures the period of a square-wave tone on one input pin, classifies it against the same 13-note table (codes 1..13, 0 = silence/unknown), and presents a debounced note code for the CPU to read. It sits beside the GPIO block on ioc and runs in the clk_125mhz domain; the system wrapper maps its outputs onto a read-only I/O address.

Parameters:
TOL, 256, allowed ±deviation in clk_125mhz cycles between a measured period and the table period
LOCK_N, 4, number of consecutive equal classifications required before note changes (1..15)
TIMEOUT, 131071, cycles without a rising edge before note is forced to 0 (must be ≤ 2^17−1)

Ports:
clk_125mhz  input  1  system clock
reset  input  1  asynchronous, active-high reset
tone_in  input  1  asynchronous tone pin (e.g. ioc[0])
note  output  8  decoded note code, 0 = none, 1..13 = C..C'
valid  output  1  high when note != 0
change  output  1  one-cycle pulse when note takes a new value
period  output  17  last measured period in clk_125mhz cycles

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk_125mhz. All flops, including synchronizers, clear on reset.
- Reset values: note=0, valid=0, change=0, period=0, cnt=0, cand=0, run=0, state=IDLE, sync chain=0.
- Input path: 3-flop chain s1→s2→s3. rise = s2 & ~s3. A pin rising edge appears as rise 3 cycles later.
- Period counter cnt (17 b):
  - On a rise cycle, cnt←1.
  - Otherwise cnt←cnt+1, saturating at 2^17−1.
  - On a rise cycle, the value cnt holds before update is the period P.
- Table periods are 4k+2 cycles, matching the generator at 62.5 MHz:
  - 1 C=59726, 2 C#=56374, 3 D=53210, 4 D#=50222, 5 E=47402, 6 F=44742, 7 F#=42234.
  - 8 G=39862, 9 G#=37626, 10 A=35514, 11 A#=33522, 12 B=31638, 13 C'=29862.
- Classification: code = i if |P − PER_i| ≤ TOL (inclusive), else 0. TOL < half the smallest gap (888), so at most one match is possible.
- States:
  - IDLE: waiting for a first edge. On rise → TRACK; P is not classified and period is not updated.
  - TRACK: on each rise, period←P, classify, then update lock.
  - Any state: when cnt reaches TIMEOUT with no rise → IDLE, note←0, cand←0, run←0. change pulses if note was nonzero.
- Lock logic (TRACK, rise cycle):
  - If code==cand: run←min(run+1, LOCK_N).
  - Otherwise: cand←code, run←1.
  - The new run value is compared. If it equals LOCK_N and cand≠note, then note←cand and change=1 on the following cycle.
  - LOCK_N consecutive invalid periods therefore drive note to 0.
- Latency: note updates 1 cycle after the rise that completes the LOCK_N-th matching period.
- Simultaneous events: a rise in the same cycle cnt would reach TIMEOUT → the rise wins and timeout is not taken.
- valid is combinational from note. change never stays high for two consecutive cycles.
- Reset mid-measurement discards all history. After release, LOCK_N+1 rising edges are needed to lock.

Test Plan:
- Reset, tone_in held 0 for 200000 cycles → note=0, valid=0, change never asserted, period=0.
- Square wave with period 59726 (C), 8 cycles → after the 5th rise (LOCK_N=4 periods) note=1, valid=1, one change pulse; period=59726.
- Lock on A (35514), then switch to B (31638) → note stays 10 for the next 3 B periods and becomes 12 on the 4th; single change pulse.
- Period 29862+256 → note=13. Period 29862+257 (invalid) for 4 periods → note→0. Period 45000 → classified 0.
- Locked on E, stop edges → note=0 exactly TIMEOUT cycles after the last cnt←1, with one change pulse. Restarting E relocks after 5 rises.
- Locked on G, assert reset for 3 cycles mid-period → all outputs 0 immediately (asynchronous); relock requires 5 fresh rises.

Source files
------------

// File: rtl/tone_decoder.sv
`timescale 1ns/1ps
// Tone period decoder: synchronises a square-wave pin, measures rising-edge spacing and maps it
// onto the 13-note beep table, with an LOCK_N-period debounce and a silence timeout.
module tone_decoder #(
    parameter int unsigned TOL     = 256,
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned TIMEOUT = 131071,
    // Note periods, code 13 in the MSBs down to code 1 in the LSBs, 17 bits each.
    parameter logic [220:0] PER_TAB = {
        17'd29862, 17'd31638, 17'd33522, 17'd35514, 17'd37626, 17'd39862, 17'd42234,
        17'd44742, 17'd47402, 17'd50222, 17'd53210, 17'd56374, 17'd59726
    }
) (
    input  logic        clk_125mhz,
    input  logic        reset,
    input  logic        tone_in,
    output logic [7:0]  note,
    output logic        valid,
    output logic        change,
    output logic [16:0] period
);

    localparam int unsigned PW    = 17;
    localparam int unsigned NOTES = 13;

    localparam logic [16:0] CNT_MAX   = 17'h1FFFF;
    localparam logic [16:0] TIMEOUT_V = 17'(TIMEOUT);
    localparam logic [3:0]  LOCK_V    = 4'(LOCK_N);
    localparam logic [17:0] TOL_V     = 18'(TOL);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Table lookup; the tolerance is below half the smallest gap, so at most one entry matches.
    function automatic logic [7:0] classify(input logic [16:0] p);
        logic [7:0]  code;
        logic [16:0] ref_p;
        logic [17:0] diff;
        code = 8'd0;
        for (int i = 0; i < int'(NOTES); i++) begin
            ref_p = PER_TAB[i*PW +: PW];
            diff  = (p >= ref_p) ? {1'b0, p - ref_p} : {1'b0, ref_p - p};
            code  = (diff <= TOL_V) ? 8'(i + 1) : code;
        end
        return code;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [16:0] cnt_q, cnt_d;
    logic [16:0] period_q, period_d;
    logic [7:0]  note_q, note_d;
    logic [7:0]  cand_q, cand_d;
    logic [3:0]  run_q, run_d;
    logic        change_q, change_d;
    logic        valid_q, valid_d;

    logic        rise_s;
    logic [7:0]  meas_code_s;
    logic [3:0]  run_inc_s;

    // Next-state: edge detect, period counter, lock/debounce and timeout handling.
    always_comb begin
        sync_d      = {sync_q[1:0], tone_in};
        rise_s      = sync_q[1] & ~sync_q[2];
        meas_code_s = classify(cnt_q);
        run_inc_s   = (run_q >= LOCK_V) ? LOCK_V : run_q + 4'd1;

        state_d  = state_q;
        period_d = period_q;
        note_d   = note_q;
        cand_d   = cand_q;
        run_d    = run_q;
        change_d = 1'b0;

        if (rise_s) begin
            cnt_d = 17'd1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 17'd1;
        end

        // A rise takes priority over a timeout landing in the same cycle.
        if (rise_s) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    period_d = cnt_q;
                    if (meas_code_s == cand_q) begin
                        run_d = run_inc_s;
                    end else begin
                        cand_d = meas_code_s;
                        run_d  = 4'd1;
                    end
                    if ((run_d == LOCK_V) && (cand_d != note_q)) begin
                        note_d   = cand_d;
                        change_d = 1'b1;
                    end else begin
                        note_d   = note_q;
                        change_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (cnt_q == TIMEOUT_V) begin
            state_d  = ST_IDLE;
            note_d   = 8'd0;
            cand_d   = 8'd0;
            run_d    = 4'd0;
            change_d = (note_q != 8'd0);
        end else begin
            state_d = state_q;
        end

        valid_d = (note_d != 8'd0);
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sync_q   <= 3'b000;
            cnt_q    <= 17'd0;
            period_q <= 17'd0;
            note_q   <= 8'd0;
            cand_q   <= 8'd0;
            run_q    <= 4'd0;
            change_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            note_q   <= note_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
            change_q <= change_d;
            valid_q  <= valid_d;
        end
    end

    assign note   = note_q;
    assign valid  = valid_q;
    assign change = change_q;
    assign period = period_q;

endmodule
